p18_game_sequencer: RTL and testbench

//   Game-flow controller for the breakout playfield. Owns the spare-ball count

---
 rtl/p18_game_sequencer.sv | 129 ++++++++++++
 tb/tb_p18_game_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/p18_game_sequencer.sv
// Breakout game-flow controller: serve / play / lost / clear / over phases,
// spare-ball count, and ball hold / launch / level-reload strobes.
module p18_game_sequencer #(
  parameter logic [1:0] START_LIVES  = 2'd3,
  parameter logic [7:0] SERVE_FRAMES = 8'd60,
  parameter logic [7:0] PAUSE_FRAMES = 8'd90,
  parameter logic [7:0] OVER_FRAMES  = 8'd180
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       ball_lost,
  input  logic       bricks_cleared,
  output logic [1:0] lives,
  output logic       lives_blink,
  output logic       ball_hold,
  output logic       ball_launch,
  output logic       level_reset,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    LOST  = 3'd3,
    CLEAR = 3'd4,
    OVER  = 3'd5
  } st_t;

  st_t        st;
  logic       start_q;
  logic [7:0] frame_cnt;
  logic [7:0] cnt_dec;
  logic       start_edge;
  logic       expire;

  assign state      = st;
  assign start_edge = start_btn & ~start_q;
  assign expire     = frame_tick && (frame_cnt == 8'd0);
  assign cnt_dec    = (frame_tick && (frame_cnt != 8'd0)) ? frame_cnt - 8'd1 : frame_cnt;

  // Outputs are set from the state being entered so they line up with state.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      st          <= IDLE;
      start_q     <= 1'b0;
      frame_cnt   <= 8'd0;
      lives       <= 2'd0;
      lives_blink <= 1'b0;
      ball_hold   <= 1'b1;
      ball_launch <= 1'b0;
      level_reset <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      start_q     <= start_btn;
      frame_cnt   <= cnt_dec;
      ball_launch <= 1'b0;
      level_reset <= 1'b0;
      lives_blink <= 1'b0;
      case (st)
        IDLE: begin
          ball_hold <= 1'b1;
          game_over <= 1'b0;
          if (start_edge) begin
            lives       <= START_LIVES;
            level_reset <= 1'b1;
            frame_cnt   <= SERVE_FRAMES;
            st          <= SERVE;
          end
        end
        SERVE: if (expire || start_edge) begin
          ball_launch <= 1'b1;
          ball_hold   <= 1'b0;
          st          <= PLAY;
        end
        PLAY: begin
          // A clear beats a simultaneous loss, so no life is taken.
          if (bricks_cleared) begin
            st        <= CLEAR;
            frame_cnt <= PAUSE_FRAMES;
            ball_hold <= 1'b1;
          end else if (ball_lost) begin
            st          <= LOST;
            frame_cnt   <= PAUSE_FRAMES;
            ball_hold   <= 1'b1;
            lives_blink <= PAUSE_FRAMES[3];
          end
        end
        LOST: begin
          if (expire) begin
            if (lives == 2'd0) begin
              st        <= OVER;
              frame_cnt <= OVER_FRAMES;
              game_over <= 1'b1;
            end else begin
              lives     <= lives - 2'd1;
              frame_cnt <= SERVE_FRAMES;
              st        <= SERVE;
            end
          end else begin
            lives_blink <= cnt_dec[3];
          end
        end
        CLEAR: if (expire) begin
          if (lives != 2'd3) lives <= lives + 2'd1;
          level_reset <= 1'b1;
          frame_cnt   <= SERVE_FRAMES;
          st          <= SERVE;
        end
        OVER: begin
          lives <= 2'd0;
          if (expire) begin
            st        <= IDLE;
            game_over <= 1'b0;
          end
        end
        default: begin
          st        <= IDLE;
          ball_hold <= 1'b1;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p18_game_sequencer.sv
// Directed + random bench for p18_game_sequencer against a phase-level model.
module tb_p18_game_sequencer;
  logic       clk = 1'b0;
  logic       nRst;
  logic       frame_tick, start_btn, ball_lost, bricks_cleared;
  logic [1:0] lives;
  logic       lives_blink, ball_hold, ball_launch, level_reset, game_over;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  p18_game_sequencer dut (
    .clk(clk), .nRst(nRst), .frame_tick(frame_tick), .start_btn(start_btn),
    .ball_lost(ball_lost), .bricks_cleared(bricks_cleared), .lives(lives),
    .lives_blink(lives_blink), .ball_hold(ball_hold), .ball_launch(ball_launch),
    .level_reset(level_reset), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: phase number, spare balls, frames left, last button level.
  int m_phase, m_lives, m_frames, m_btn;
  int m_launch, m_reload;

  task automatic model_reset();
    m_phase = 0; m_lives = 0; m_frames = 0; m_btn = 0; m_launch = 0; m_reload = 0;
  endtask

  task automatic model_step(input int ft, input int sb, input int bl, input int bc);
    bit pressed, timeout;
    pressed  = (sb != 0) && (m_btn == 0);
    timeout  = (ft != 0) && (m_frames == 0);
    m_btn    = sb;
    if (ft != 0 && m_frames > 0) m_frames = m_frames - 1;
    m_launch = 0;
    m_reload = 0;
    if (m_phase == 0) begin
      if (pressed) begin m_lives = 3; m_reload = 1; m_frames = 60; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (timeout || pressed) begin m_launch = 1; m_phase = 2; end
    end else if (m_phase == 2) begin
      if (bc != 0) begin m_phase = 4; m_frames = 90; end
      else if (bl != 0) begin m_phase = 3; m_frames = 90; end
    end else if (m_phase == 3) begin
      if (timeout) begin
        if (m_lives == 0) begin m_phase = 5; m_frames = 180; end
        else begin m_lives = m_lives - 1; m_frames = 60; m_phase = 1; end
      end
    end else if (m_phase == 4) begin
      if (timeout) begin
        m_lives  = (m_lives + 1 > 3) ? 3 : m_lives + 1;
        m_reload = 1; m_frames = 60; m_phase = 1;
      end
    end else if (m_phase == 5) begin
      if (timeout) m_phase = 0;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state",       {29'd0, state},       m_phase);
    chk("lives",       {30'd0, lives},       m_lives);
    chk("ball_hold",   {31'd0, ball_hold},   (m_phase != 2) ? 1 : 0);
    chk("game_over",   {31'd0, game_over},   (m_phase == 5) ? 1 : 0);
    chk("lives_blink", {31'd0, lives_blink}, (m_phase == 3 && ((m_frames >> 3) & 1) == 1) ? 1 : 0);
    chk("ball_launch", {31'd0, ball_launch}, m_launch);
    chk("level_reset", {31'd0, level_reset}, m_reload);
  endtask

  task automatic cyc(input int ft, input int sb, input int bl, input int bc);
    frame_tick = ft[0]; start_btn = sb[0]; ball_lost = bl[0]; bricks_cleared = bc[0];
    @(posedge clk);
    model_step(ft, sb, bl, bc);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n, input int sb);
    for (int i = 0; i < n; i++) begin
      cyc(1, sb, 0, 0);
      cyc(0, sb, 0, 0);
    end
  endtask

  task automatic do_reset();
    frame_tick = 0; start_btn = 0; ball_lost = 0; bricks_cleared = 0;
    nRst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_lives", {30'd0, lives}, 0);
    chk("rst_hold",  {31'd0, ball_hold}, 1);
    nRst = 1'b1;
    #1;
  endtask

  initial begin
    nRst = 1'b0;
    do_reset();

    // Start press: reload + lives + SERVE next clock.
    cyc(0, 1, 0, 0);
    chk("start_state", {29'd0, state}, 1);
    chk("start_lives", {30'd0, lives}, 3);
    chk("start_reload", {31'd0, level_reset}, 1);

    // Held button is not a new edge; auto-launch on the 61st tick.
    ticks(60, 1);
    chk("serve_wait", {29'd0, state}, 1);
    cyc(1, 1, 0, 0);
    chk("auto_launch", {31'd0, ball_launch}, 1);
    chk("auto_play", {29'd0, state}, 2);
    chk("auto_hold", {31'd0, ball_hold}, 0);
    cyc(0, 0, 0, 0);

    // Four losses: 3 -> 2 -> 1 -> 0 -> OVER, with ignored inputs sprinkled in.
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, 0);
      chk("lost_enter", {29'd0, state}, 3);
      cyc(0, 1, 1, 0);
      cyc(0, 0, 0, 1);
      ticks(90, 0);
      cyc(1, 0, 0, 0);
      if (k < 3) begin
        chk("lost_serve", {29'd0, state}, 1);
        chk("lost_lives", {30'd0, lives}, 2 - k);
        cyc(0, 0, 1, 0);
        chk("serve_ignore_lost", {29'd0, state}, 1);
        cyc(0, 1, 0, 0);
        chk("fire_launch", {31'd0, ball_launch}, 1);
        cyc(0, 0, 0, 0);
      end else begin
        chk("over_state", {29'd0, state}, 5);
        chk("over_flag", {31'd0, game_over}, 1);
      end
    end

    // Start edge ignored in OVER, then back to IDLE after 181 ticks.
    cyc(0, 1, 0, 0);
    chk("over_ignore_start", {29'd0, state}, 5);
    cyc(0, 0, 0, 0);
    ticks(180, 0);
    cyc(1, 0, 0, 0);
    chk("over_to_idle", {29'd0, state}, 0);
    chk("over_clear", {31'd0, game_over}, 0);
    cyc(0, 0, 1, 0);
    chk("idle_ignore_lost", {29'd0, state}, 0);

    // Simultaneous loss + clear: CLEAR wins, lives saturate at 3.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 1);
    chk("both_clear", {29'd0, state}, 4);
    chk("both_lives", {30'd0, lives}, 3);
    ticks(90, 0);
    cyc(1, 0, 0, 0);
    chk("clear_reload", {31'd0, level_reset}, 1);
    chk("clear_sat", {30'd0, lives}, 3);

    // Lose one, then clear: 2 -> 3.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    ticks(90, 0);
    cyc(1, 0, 0, 0);
    chk("loss_to2", {30'd0, lives}, 2);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    ticks(90, 0);
    cyc(1, 0, 0, 0);
    chk("clear_inc", {30'd0, lives}, 3);

    // Random play checked every cycle against the model.
    begin
      int sb = 0;
      for (int i = 0; i < 6000; i++) begin
        if ($urandom_range(0, 15) == 0) sb = 1 - sb;
        cyc(($urandom_range(0, 3) == 0) ? 1 : 0, sb,
            ($urandom_range(0, 39) == 0) ? 1 : 0,
            ($urandom_range(0, 79) == 0) ? 1 : 0);
      end
    end

    // Async reset in the middle of LOST, button held through release.
    do_reset();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    ticks(5, 0);
    chk("pre_rst_lost", {29'd0, state}, 3);
    #2;
    nRst = 1'b0;
    start_btn = 1'b1;
    model_reset();
    #1;
    chk("async_state", {29'd0, state}, 0);
    chk("async_lives", {30'd0, lives}, 0);
    chk("async_hold", {31'd0, ball_hold}, 1);
    chk("async_blink", {31'd0, lives_blink}, 0);
    chk("async_over", {31'd0, game_over}, 0);
    @(negedge clk);
    nRst = 1'b1;
    cyc(0, 1, 0, 0);
    chk("held_start", {29'd0, state}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
